// File: rtl/pixel_pack_fifo_pkg.sv
// Shared constants for the 24-to-64 pixel packer: widths, accumulator steps and err bit indices.
// The optional err port is enabled with PIXEL_PACK_ERR_EN.
package pixel_pack_fifo_pkg;

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned WORD_W = 64;
    localparam int unsigned ACC_W  = 80;
    localparam int unsigned BITS_W = 7;
    localparam int unsigned CNT_W  = 4;

    localparam logic [BITS_W-1:0] PIX_STEP    = 7'd24;
    localparam logic [BITS_W-1:0] WORD_STEP   = 7'd64;
    localparam logic [BITS_W-1:0] FULL_THRESH = 7'd40;

    localparam int unsigned ERR_W         = 2;
    localparam int unsigned ERR_PUSH_FULL = 0;
    localparam int unsigned ERR_POP_EMPTY = 1;

    // Keeps only the bits below the fill level of a partial word.
    function automatic logic [WORD_W-1:0] low_mask(input logic [BITS_W-1:0] bits);
        return ~({WORD_W{1'b1}} << bits);
    endfunction

endpackage

// File: rtl/pack_word_fifo.sv
// Generic DEPTH x WORD_W first-word-fall-through FIFO with occupancy count.
// Head reads as zero when empty; illegal strobes are ignored.
module pack_word_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WORD_W = 64,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign wr_ok   = wr_en && (count != CNT_W'(DEPTH));
    assign rd_ok   = rd_en && (count != '0);
    assign rd_data = (count == '0) ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap at DEPTH, which need not be a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_pack_fifo.sv
// Packs 24-bit pixels little-endian into 64-bit words and buffers them in a word FIFO.
// Define PIXEL_PACK_ERR_EN to add the sticky err[1:0] illegal-strobe flags.
module pixel_pack_fifo
    import pixel_pack_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [PIX_W-1:0]  data_in,
    input  logic              push,
    input  logic              flush,
    input  logic              pop,
    output logic [WORD_W-1:0] data_o,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              flush_busy
`ifdef PIXEL_PACK_ERR_EN
    ,
    output logic [ERR_W-1:0]  err
`endif
);

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_p;
    logic [ACC_W-1:0]  acc_n;
    logic [BITS_W-1:0] acc_bits;
    logic [BITS_W-1:0] bits_p;
    logic [BITS_W-1:0] bits_n;
    logic              busy_n;
    logic              push_ok;
    logic              push_emit;
    logic              flush_req;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              fifo_full;

    assign fifo_full = (count == CNT_W'(DEPTH));
    assign full      = fifo_full && ((acc_bits >= FULL_THRESH) || flush_busy);

    // Pixel is packed first; a flush only ever sees the residue left after it.
    always_comb begin
        push_ok   = push && !full;
        acc_p     = acc;
        bits_p    = acc_bits;
        push_emit = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        busy_n    = flush_busy;

        if (push_ok) begin
            acc_p  = acc | (ACC_W'(data_in) << acc_bits);
            bits_p = acc_bits + PIX_STEP;
        end

        acc_n  = acc_p;
        bits_n = bits_p;

        if (bits_p >= WORD_STEP) begin
            push_emit = 1'b1;
            wr_en     = 1'b1;
            wr_data   = acc_p[WORD_W-1:0];
            acc_n     = acc_p >> WORD_W;
            bits_n    = bits_p - WORD_STEP;
        end

        flush_req = flush_busy || (flush && (bits_n != '0));

        if (flush_req) begin
            if (bits_n == '0) begin
                busy_n = 1'b0;
            end else if (!push_emit && !fifo_full) begin
                wr_en   = 1'b1;
                wr_data = acc_n[WORD_W-1:0] & low_mask(bits_n);
                acc_n   = '0;
                bits_n  = '0;
                busy_n  = 1'b0;
            end else begin
                busy_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_bits   <= '0;
            flush_busy <= 1'b0;
        end else begin
            acc        <= acc_n;
            acc_bits   <= bits_n;
            flush_busy <= busy_n;
        end
    end

`ifdef PIXEL_PACK_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= '0;
        end else begin
            if (push && full) begin
                err[ERR_PUSH_FULL] <= 1'b1;
            end
            if (pop && (count == '0)) begin
                err[ERR_POP_EMPTY] <= 1'b1;
            end
        end
    end
`endif

    pack_word_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_word_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (data_o),
        .count   (count)
    );

endmodule

// File: doc/pixel_pack_fifo.md
Name: pixel_pack_fifo

Overview:
- Output-side counterpart of the input-layer 64-to-24 unpacking FIFO.
- Accepts 24-bit pixels one per push and packs them densely, little-endian, into 64-bit words.
- Finished words are buffered in a small word FIFO and drained by a downstream 64-bit writer with pop.
- Sits at the end of the layer pipeline, ahead of the memory write-back path.

Parameters:
- DEPTH, 8: number of 64-bit words the word FIFO holds (2..15).
- PIX_W, 24: pixel width. Fixed at 24; the packing schedule below depends on it.
- WORD_W, 64: output word width. Fixed at 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  24  pixel to pack.
- push  in  1  pixel write strobe; data_in is taken when push=1 and full=0.
- flush  in  1  one-cycle request to emit any partial word, zero-padded.
- pop  in  1  word read strobe; the word FIFO head is removed when pop=1 and count!=0.
- data_o  out  64  word FIFO head, first-word-fall-through; all zeros when empty.
- count  out  4  number of complete words held, 0..DEPTH.
- full  out  1  push would be rejected this cycle.
- flush_busy  out  1  a flush is pending and has not yet been emitted.

Behaviour:
- Reset: all outputs 0. This covers data_o, count, full and flush_busy. Accumulator, its fill level acc_bits, and the read/write pointers are also cleared.
- Reset is asynchronous and may be asserted mid-operation. Any partial word and all buffered words are discarded.
- Accumulator:
  - acc is 80 bits; acc_bits takes one of {0,8,16,24,32,40,48,56}.
  - On an accepted push: acc |= data_in << acc_bits, then acc_bits += 24.
  - If acc_bits reaches 64 or more: acc[63:0] is written to the word FIFO, acc shifts right by 64, and acc_bits -= 64.
  - Resulting fill sequence from reset: 0, 24, 48, 8*, 32, 56, 16*, 40, 0*. A * marks a cycle where a word is emitted; 8 pixels produce 3 words.
- full = (count==DEPTH) && (acc_bits>=40 || flush_busy).
  - full is computed from registered state only.
  - A pop in the same cycle does not un-reject a push.
- Pop:
  - count decrements and data_o advances to the next word on the following cycle.
  - A pop with count==0 is ignored.
- Simultaneous push (emitting a word) and pop: count stays unchanged, pointers both advance.
- Flush:
  - If asserted with acc_bits==0 and no pending flush: no action.
  - Otherwise flush_busy sets. Once the word FIFO has space, acc[63:0] is written with bits at and above acc_bits zeroed, then acc_bits=0 and flush_busy=0.
  - A push in the same cycle as flush is packed first; the flush then covers that pixel.
  - While flush_busy=1, push is rejected when the FIFO is full. Otherwise the pixel is accepted and packed before the pending flush completes.
- Word emission happens at most once per cycle. Push-emission and flush-emission never coincide: the flush takes the residue after the pushed pixel.
- Pointers wrap modulo DEPTH.
- Latency: a completed word appears at data_o (count>=1) the cycle after the completing push.

Optional Feature:
- Macro: PIXEL_PACK_ERR_EN.
- When defined, adds output err[1:0], cleared at reset:
  - err[0] sticky on push while full.
  - err[1] sticky on pop while count==0.
  - Both flags are cleared only by reset.
- When undefined, no err port exists and illegal strobes are silently ignored.

Decomposition:
- Shared layer package holds:
  - constants PIX_W=24 and WORD_W=64;
  - the acc_bits step values (24, 64);
  - the err bit indices.
- One sub-module is natural: pack_word_fifo, a generic DEPTH x 64 first-word-fall-through FIFO with count. pixel_pack_fifo keeps the accumulator, flush logic and full calculation.

Test Plan:
- Reset, then push AABBCC, 112233, 445566 -> count=1, data_o=64'h5566112233AABBCC, acc_bits=8.
- Continue pushing 778899, DDEEFF, 000001 -> second word 64'h01DDEEFF77889944, count=2, acc_bits=16 with zero residue.
- After one pixel ABCDEF at acc_bits=0, pulse flush -> next cycle count=1, data_o=64'h0000000000ABCDEF, flush_busy=0.
- Fill to count=8 with acc_bits=40 -> full=1; push 123456 rejected. Pop once -> full=0 next cycle; push is then accepted and emits a word, count=8.
- Simultaneous push completing a word and pop at count=3 -> count stays 3; words are popped in the original push order.
- Assert reset_n=0 mid-stream (count=2, acc_bits=32) -> count=0, data_o=0, full=0 immediately. With PIXEL_PACK_ERR_EN, a pop at count=0 sets err[1]=1.
